sma_window_ctrl: RTL and testbench

SMA_WINDOW_CTRL -- requirements
Module: sma_window_ctrl

---
 rtl/sma_ctrl_pkg.sv | 28 ++
 rtl/sma_window_ctrl_if.sv | 12 +
 rtl/sma_fill_cnt.sv | 26 ++
 rtl/sma_window_ctrl.sv | 94 +++++++++
 tb/tb_sma_window_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sma_ctrl_pkg.sv
// Shared encodings, select-range defaults and the window_sel clamp used by the SMA window controller.
package sma_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    localparam int unsigned MIN_SEL_DEF     = 0;
    localparam int unsigned MAX_SEL_DEF     = 13;
    localparam int unsigned DEFAULT_SEL_DEF = 12;

    localparam int CNT_W     = 14;
    localparam int SEL_IDX_W = 4;

    function automatic logic [31:0] clamp_sel(input logic [31:0] req,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        logic [31:0] r;
        if (req < lo)      r = lo;
        else if (req > hi) r = hi;
        else               r = req;
        return r;
    endfunction

endpackage

// File: rtl/sma_window_ctrl_if.sv
// Bundle between the window controller and its fill counter.
interface sma_window_ctrl_if;
    import sma_ctrl_pkg::*;

    logic                 clear;
    logic                 inc;
    logic [SEL_IDX_W-1:0] sel;
    logic                 done;

    modport master (output clear, inc, sel, input done);
    modport slave  (input clear, inc, sel, output done);
endinterface

// File: rtl/sma_fill_cnt.sv
// Counts forwarded strobes during fill; done flags the increment that reaches 2^sel.
module sma_fill_cnt
    import sma_ctrl_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    sma_window_ctrl_if.slave fc
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] target;

    assign cnt_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign target  = {{(CNT_W-1){1'b0}}, 1'b1} << fc.sel;

    // Done is combinational so the FSM enters RUN on the same edge the count lands on target.
    assign fc.done = fc.inc && (cnt_inc == target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (fc.clear) cnt <= '0;
        else if (fc.inc)   cnt <= cnt_inc;
    end

endmodule

// File: rtl/sma_window_ctrl.sv
// Window-select controller for the SMA: clamps requests, defers select changes to a
// strobe boundary, and reports when the average has refilled under the current window.
module sma_window_ctrl
    import sma_ctrl_pkg::*;
#(
    parameter int unsigned MIN_SEL     = MIN_SEL_DEF,
    parameter int unsigned MAX_SEL     = MAX_SEL_DEF,
    parameter int unsigned DEFAULT_SEL = DEFAULT_SEL_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_update_strobe,
    input  logic [31:0] i_win_req,
    input  logic        i_win_req_wr,
    input  logic        i_err_clr,
    output logic [31:0] o_window_sel,
    output logic        o_sma_strobe,
    output logic        o_avg_valid,
    output logic        o_range_err,
    output logic [1:0]  o_state
);

    state_t      state, state_nxt;
    logic [31:0] pending, pending_nxt;
    logic [31:0] req_clamped;
    logic        clamped_hit;
    logic        sel_change;
    logic        sel_load;

    sma_window_ctrl_if fc ();

    sma_fill_cnt u_fill_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .fc    (fc)
    );

    assign req_clamped = clamp_sel(i_win_req, MIN_SEL, MAX_SEL);
    assign clamped_hit = i_win_req_wr && (req_clamped != i_win_req);
    assign sel_change  = i_win_req_wr && (req_clamped != o_window_sel);

    assign fc.clear = sel_load;
    assign fc.inc   = o_sma_strobe && (state == ST_FILL);
    assign fc.sel   = o_window_sel[SEL_IDX_W-1:0];
    assign o_state  = state;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        sel_load    = 1'b0;
        case (state)
            ST_FILL, ST_RUN: begin
                // A real change abandons any fill; the select itself waits for a strobe.
                if (sel_change) begin
                    state_nxt   = ST_PEND;
                    pending_nxt = req_clamped;
                end else if (state == ST_FILL && fc.done) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_PEND: begin
                if (i_win_req_wr) pending_nxt = req_clamped;
                if (i_update_strobe) begin
                    sel_load  = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_FILL;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_window_sel <= DEFAULT_SEL;
            pending      <= DEFAULT_SEL;
            o_sma_strobe <= 1'b0;
            o_avg_valid  <= 1'b0;
            o_range_err  <= 1'b0;
        end else begin
            pending      <= pending_nxt;
            if (sel_load) o_window_sel <= pending_nxt;
            o_sma_strobe <= i_update_strobe;
            o_avg_valid  <= (state_nxt == ST_RUN);
            if (clamped_hit)    o_range_err <= 1'b1;
            else if (i_err_clr) o_range_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sma_window_ctrl.sv
// Directed bench for sma_window_ctrl with DEFAULT_SEL=2 and a strobe every 10 clocks.
module tb_sma_window_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_update_strobe;
    logic [31:0] i_win_req;
    logic        i_win_req_wr;
    logic        i_err_clr;
    logic [31:0] o_window_sel;
    logic        o_sma_strobe;
    logic        o_avg_valid;
    logic        o_range_err;
    logic [1:0]  o_state;

    int checks = 0;
    int errors = 0;

    sma_window_ctrl #(.MIN_SEL(0), .MAX_SEL(13), .DEFAULT_SEL(2)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_update_strobe (i_update_strobe),
        .i_win_req       (i_win_req),
        .i_win_req_wr    (i_win_req_wr),
        .i_err_clr       (i_err_clr),
        .o_window_sel    (o_window_sel),
        .o_sma_strobe    (o_sma_strobe),
        .o_avg_valid     (o_avg_valid),
        .o_range_err     (o_range_err),
        .o_state         (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic strobe_once();
        i_update_strobe = 1'b1;
        tick(1);
        i_update_strobe = 1'b0;
    endtask

    task automatic write_req(input logic [31:0] v);
        i_win_req    = v;
        i_win_req_wr = 1'b1;
        tick(1);
        i_win_req_wr = 1'b0;
    endtask

    task automatic fill_strobes(input int n);
        repeat (n) begin
            strobe_once();
            tick(9);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick(2);
        checks++; if (o_window_sel !== 32'd2) begin errors++; $display("FAIL reset_sel: got %0d expected 2", o_window_sel); end
        checks++; if (o_sma_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", o_sma_strobe); end
        checks++; if (o_avg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_avg_valid); end
        checks++; if (o_range_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_range_err); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
        i_rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_reset_fill();
        logic exp_v;
        for (int k = 1; k <= 4; k++) begin
            strobe_once();
            checks++; if (o_sma_strobe !== 1'b1) begin errors++; $display("FAIL fill_fwd%0d: got %b expected 1", k, o_sma_strobe); end
            checks++; if (o_window_sel !== 32'd2) begin errors++; $display("FAIL fill_sel%0d: got %0d expected 2", k, o_window_sel); end
            checks++; if (o_avg_valid !== 1'b0) begin errors++; $display("FAIL fill_early%0d: got %b expected 0", k, o_avg_valid); end
            tick(1);
            exp_v = (k == 4);
            checks++; if (o_avg_valid !== exp_v) begin errors++; $display("FAIL fill_valid%0d: got %b expected %b", k, o_avg_valid, exp_v); end
            tick(8);
        end
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL fill_run: got %0d expected 1", o_state); end
    endtask

    task automatic test_change_run();
        logic exp_v;
        write_req(32'd3);
        checks++; if (o_avg_valid !== 1'b0) begin errors++; $display("FAIL chg_fall: got %b expected 0", o_avg_valid); end
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL chg_pend: got %0d expected 2", o_state); end
        checks++; if (o_window_sel !== 32'd2) begin errors++; $display("FAIL chg_hold: got %0d expected 2", o_window_sel); end
        tick(3);
        for (int k = 1; k <= 8; k++) begin
            strobe_once();
            checks++; if (o_window_sel !== 32'd3) begin errors++; $display("FAIL chg_sel%0d: got %0d expected 3", k, o_window_sel); end
            tick(1);
            exp_v = (k == 8);
            checks++; if (o_avg_valid !== exp_v) begin errors++; $display("FAIL chg_valid%0d: got %b expected %b", k, o_avg_valid, exp_v); end
            tick(8);
        end
    endtask

    task automatic test_same_value();
        write_req(32'd3);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL same_state: got %0d expected 1", o_state); end
        checks++; if (o_avg_valid !== 1'b1) begin errors++; $display("FAIL same_valid: got %b expected 1", o_avg_valid); end
        checks++; if (o_range_err !== 1'b0) begin errors++; $display("FAIL same_err: got %b expected 0", o_range_err); end
    endtask

    task automatic test_range();
        write_req(32'd20);
        checks++; if (o_range_err !== 1'b1) begin errors++; $display("FAIL rng_set: got %b expected 1", o_range_err); end
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL rng_pend: got %0d expected 2", o_state); end
        checks++; if (o_window_sel !== 32'd3) begin errors++; $display("FAIL rng_hold: got %0d expected 3", o_window_sel); end
        i_err_clr = 1'b1;
        tick(1);
        i_err_clr = 1'b0;
        checks++; if (o_range_err !== 1'b0) begin errors++; $display("FAIL rng_clr: got %b expected 0", o_range_err); end
        i_win_req    = 32'hFFFF_FFFF;
        i_win_req_wr = 1'b1;
        i_err_clr    = 1'b1;
        tick(1);
        i_win_req_wr = 1'b0;
        i_err_clr    = 1'b0;
        checks++; if (o_range_err !== 1'b1) begin errors++; $display("FAIL rng_setwins: got %b expected 1", o_range_err); end
        strobe_once();
        checks++; if (o_window_sel !== 32'd13) begin errors++; $display("FAIL rng_max: got %0d expected 13", o_window_sel); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL rng_fill: got %0d expected 0", o_state); end
        tick(9);
        i_err_clr = 1'b1;
        tick(1);
        i_err_clr = 1'b0;
        write_req(32'd2);
        checks++; if (o_range_err !== 1'b0) begin errors++; $display("FAIL rng_inrange: got %b expected 0", o_range_err); end
        checks++; if (o_window_sel !== 32'd13) begin errors++; $display("FAIL rng_hold13: got %0d expected 13", o_window_sel); end
        fill_strobes(4);
        checks++; if (o_window_sel !== 32'd2) begin errors++; $display("FAIL rng_back: got %0d expected 2", o_window_sel); end
        checks++; if (o_avg_valid !== 1'b1) begin errors++; $display("FAIL rng_valid: got %b expected 1", o_avg_valid); end
    endtask

    task automatic test_last_write();
        write_req(32'd4);
        tick(2);
        write_req(32'd5);
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL lww_pend: got %0d expected 2", o_state); end
        checks++; if (o_window_sel !== 32'd2) begin errors++; $display("FAIL lww_hold: got %0d expected 2", o_window_sel); end
        tick(2);
        strobe_once();
        checks++; if (o_window_sel !== 32'd5) begin errors++; $display("FAIL lww_sel: got %0d expected 5", o_window_sel); end
        tick(9);
        write_req(32'd2);
        fill_strobes(4);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL lww_run: got %0d expected 1", o_state); end
    endtask

    task automatic test_back_to_back();
        i_win_req       = 32'd3;
        i_win_req_wr    = 1'b1;
        i_update_strobe = 1'b1;
        tick(1);
        i_win_req_wr    = 1'b0;
        i_update_strobe = 1'b0;
        checks++; if (o_sma_strobe !== 1'b1) begin errors++; $display("FAIL b2b_fwd: got %b expected 1", o_sma_strobe); end
        checks++; if (o_window_sel !== 32'd2) begin errors++; $display("FAIL b2b_old: got %0d expected 2", o_window_sel); end
        checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL b2b_pend: got %0d expected 2", o_state); end
        tick(9);
        strobe_once();
        checks++; if (o_window_sel !== 32'd3) begin errors++; $display("FAIL b2b_new: got %0d expected 3", o_window_sel); end
        tick(9);
        write_req(32'd2);
        tick(2);
        i_win_req       = 32'd4;
        i_win_req_wr    = 1'b1;
        i_update_strobe = 1'b1;
        tick(1);
        i_win_req_wr    = 1'b0;
        i_update_strobe = 1'b0;
        checks++; if (o_window_sel !== 32'd4) begin errors++; $display("FAIL b2b_pendwr: got %0d expected 4", o_window_sel); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL b2b_fill: got %0d expected 0", o_state); end
        tick(9);
        write_req(32'd2);
        fill_strobes(4);
        checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL b2b_run: got %0d expected 1", o_state); end
    endtask

    task automatic test_reset_mid_fill();
        write_req(32'd40);
        write_req(32'd5);
        fill_strobes(10);
        checks++; if (o_window_sel !== 32'd5) begin errors++; $display("FAIL mid_sel: got %0d expected 5", o_window_sel); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL mid_fill: got %0d expected 0", o_state); end
        checks++; if (o_range_err !== 1'b1) begin errors++; $display("FAIL mid_err: got %b expected 1", o_range_err); end
        strobe_once();
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_window_sel !== 32'd2) begin errors++; $display("FAIL mid_rst_sel: got %0d expected 2", o_window_sel); end
        checks++; if (o_sma_strobe !== 1'b0) begin errors++; $display("FAIL mid_rst_strobe: got %b expected 0", o_sma_strobe); end
        checks++; if (o_avg_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", o_avg_valid); end
        checks++; if (o_range_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b expected 0", o_range_err); end
        checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d expected 0", o_state); end
        tick(2);
        i_rst_n = 1'b1;
        tick(2);
        fill_strobes(3);
        checks++; if (o_avg_valid !== 1'b0) begin errors++; $display("FAIL mid_after3: got %b expected 0", o_avg_valid); end
        strobe_once();
        checks++; if (o_window_sel !== 32'd2) begin errors++; $display("FAIL mid_after_sel: got %0d expected 2", o_window_sel); end
        tick(1);
        checks++; if (o_avg_valid !== 1'b1) begin errors++; $display("FAIL mid_after4: got %b expected 1", o_avg_valid); end
    endtask

    initial begin
        i_rst_n         = 1'b0;
        i_update_strobe = 1'b0;
        i_win_req       = 32'd0;
        i_win_req_wr    = 1'b0;
        i_err_clr       = 1'b0;
        test_reset();
        test_reset_fill();
        test_change_run();
        test_same_value();
        test_range();
        test_last_write();
        test_back_to_back();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
